counter_monitor: RTL and testbench

COUNTER_MONITOR -- requirements
Module: counter_monitor

---
 rtl/counter_monitor_pkg.sv | 13 +
 rtl/counter_monitor.sv | 127 ++++++++++++
 tb/tb_counter_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_monitor_pkg.sv
// Shared types and constants for the counter monitor: FSM encoding and error-count sizing.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int              ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/counter_monitor.sv
// Watches a free-running counter, locks onto a clean +1 sequence, and reports
// mismatches and restarts-to-zero with registered, one-cycle-latency outputs.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     value,
  input  logic                 sample_en,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err,
  output logic                 restart,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     last_value
);

  localparam int RUN_W  = $clog2(LOCK_COUNT) + 1;
  localparam int MISS_W = $clog2(LOSS_COUNT) + 1;

  state_e               r_state;
  logic [RUN_W-1:0]     r_run;
  logic [MISS_W-1:0]    r_miss;
  logic                 r_primed;
  logic                 r_locked;
  logic                 r_err;
  logic                 r_restart;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0]     r_last;

  logic [WIDTH-1:0]  w_expected;
  logic              w_good;
  logic              w_restart;
  logic              w_mismatch;
  logic [RUN_W-1:0]  w_run_nxt;
  logic [MISS_W-1:0] w_miss_nxt;

  // All-ones -> 0 is a normal wrap; only a jump to 0 from elsewhere is a restart.
  assign w_expected = r_last + 1'b1;
  assign w_good     = (value == w_expected);
  assign w_restart  = r_primed && (value == '0) && (w_expected != '0);
  assign w_mismatch = sample_en && (r_state == ST_LOCKED) && !w_good && !w_restart;
  assign w_run_nxt  = r_run + 1'b1;
  assign w_miss_nxt = r_miss + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HUNT;
      r_run       <= '0;
      r_miss      <= '0;
      r_primed    <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_restart   <= 1'b0;
      r_err_count <= '0;
      r_last      <= '0;
    end else begin
      r_err     <= w_mismatch;
      r_restart <= sample_en && w_restart;

      // A clear coinciding with a new error leaves that error counted.
      if (err_clr)
        r_err_count <= w_mismatch ? ERR_CNT_W'(1) : '0;
      else if (w_mismatch && (r_err_count != ERR_CNT_MAX))
        r_err_count <= r_err_count + 1'b1;

      if (sample_en) begin
        r_last   <= value;
        r_primed <= 1'b1;
        if (w_restart) begin
          r_state  <= ST_ACQUIRE;
          r_run    <= '0;
          r_miss   <= '0;
          r_locked <= 1'b0;
        end else begin
          case (r_state)
            ST_HUNT: begin
              r_state <= ST_ACQUIRE;
              r_run   <= '0;
            end
            ST_ACQUIRE: begin
              if (w_good) begin
                r_run <= w_run_nxt;
                if (w_run_nxt == RUN_W'(LOCK_COUNT)) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                  r_miss   <= '0;
                end
              end else begin
                r_run <= '0;
              end
            end
            ST_LOCKED: begin
              if (w_good) begin
                r_miss <= '0;
              end else if (w_miss_nxt == MISS_W'(LOSS_COUNT)) begin
                r_state  <= ST_HUNT;
                r_locked <= 1'b0;
                r_miss   <= '0;
                r_run    <= '0;
              end else begin
                r_miss <= w_miss_nxt;
              end
            end
            default: begin
              r_state  <= ST_HUNT;
              r_locked <= 1'b0;
              r_run    <= '0;
              r_miss   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign restart    = r_restart;
  assign err_count  = r_err_count;
  assign last_value = r_last;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
// Instance 0 uses default parameters; instance 1 has a huge loss threshold for saturation runs.
module tb_counter_monitor;

  localparam int SAT_LOSS = 100000;
  localparam int M_HUNT = 0, M_ACQ = 1, M_LOCK = 2;

  typedef struct {
    int mode; int run; int miss; int last; int cnt;
    bit primed; bit lk; bit er; bit rs;
  } mdl_t;

  typedef struct { bit lk; bit er; bit rs; int cnt; int last; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] v0 = '0, v1 = '0;
  logic e0 = 1'b0, e1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
  logic lk0, er0, rs0, lk1, er1, rs1;
  logic [15:0] ec0, ec1;
  logic [7:0]  lv0, lv1;

  counter_monitor dut0 (
    .clk(clk), .reset(reset), .value(v0), .sample_en(e0), .err_clr(c0),
    .locked(lk0), .err(er0), .restart(rs0), .err_count(ec0), .last_value(lv0)
  );

  counter_monitor #(.WIDTH(8), .LOCK_COUNT(4), .LOSS_COUNT(SAT_LOSS)) dut1 (
    .clk(clk), .reset(reset), .value(v1), .sample_en(e1), .err_clr(c1),
    .locked(lk1), .err(er1), .restart(rs1), .err_count(ec1), .last_value(lv1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  mdl_t m[2];
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  // Reference model: one sampling edge, written directly from the behavioural rules.
  function automatic mdl_t mstep(mdl_t s, int loss, int v, bit en, bit clr);
    mdl_t n = s;
    bit counted = 1'b0;
    int exp_v;
    n.er = 1'b0;
    n.rs = 1'b0;
    if (en) begin
      exp_v = (s.last + 1) % 256;
      if (s.primed && v == 0 && exp_v != 0) begin
        n.rs = 1'b1; n.mode = M_ACQ; n.run = 0; n.miss = 0;
      end else if (s.mode == M_HUNT) begin
        n.mode = M_ACQ; n.run = 0;
      end else if (s.mode == M_ACQ) begin
        if (v == exp_v) begin
          n.run = s.run + 1;
          if (n.run == 4) begin n.mode = M_LOCK; n.miss = 0; end
        end else n.run = 0;
      end else begin
        if (v == exp_v) n.miss = 0;
        else begin
          n.er = 1'b1; counted = 1'b1; n.miss = s.miss + 1;
          if (n.miss == loss) begin n.mode = M_HUNT; n.miss = 0; n.run = 0; end
        end
      end
      n.last = v;
      n.primed = 1'b1;
    end
    if (clr) n.cnt = counted ? 1 : 0;
    else if (counted && s.cnt < 65535) n.cnt = s.cnt + 1;
    n.lk = (n.mode == M_LOCK);
    return n;
  endfunction

  task automatic push_step(input int idx, input int v, input bit en, input bit clr);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!reset) m[i] = '{default: 0};
      else m[i] = mstep(m[i], (i == 0) ? 2 : SAT_LOSS, (i == idx) ? v : 0,
                        (i == idx) && en, (i == idx) && clr);
      e = '{m[i].lk, m[i].er, m[i].rs, m[i].cnt, m[i].last};
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic cyc(input int idx, input int v, input bit en, input bit clr);
    logic [7:0] vb;
    vb = v[7:0];
    @(negedge clk);
    if (idx == 0) begin
      v0 = vb; e0 = en; c0 = clr; e1 = 1'b0; c1 = 1'b0;
    end else begin
      v1 = vb; e1 = en; c1 = clr; e0 = 1'b0; c0 = 1'b0;
    end
    push_step(idx, v, en, clr);
  endtask

  task automatic seq0(input int first, input int n);
    for (int k = 0; k < n; k++) cyc(0, (first + k) % 256, 1'b1, 1'b0);
  endtask

  // Pull reset between edges and check the outputs collapse without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    e0 = 1'b0; c0 = 1'b0; e1 = 1'b0; c1 = 1'b0;
    chk("pre_reset_locked", int'(lk0), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_locked", int'(lk0), 0);
    chk("arst_err", int'(er0), 0);
    chk("arst_restart", int'(rs0), 0);
    chk("arst_err_count", int'(ec0), 0);
    chk("arst_last_value", int'(lv0), 0);
    push_step(0, 0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0_locked", int'(lk0), int'(e.lk));
      chk("d0_err", int'(er0), int'(e.er));
      chk("d0_restart", int'(rs0), int'(e.rs));
      chk("d0_err_count", int'(ec0), e.cnt);
      chk("d0_last_value", int'(lv0), e.last);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1_locked", int'(lk1), int'(e.lk));
      chk("d1_err", int'(er1), int'(e.er));
      chk("d1_restart", int'(rs1), int'(e.rs));
      chk("d1_err_count", int'(ec1), e.cnt);
      chk("d1_last_value", int'(lv1), e.last);
    end
  end

  initial begin
    int r, v;
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    // Held in reset for a few cycles with sample_en active: nothing may be taken.
    for (int k = 0; k < 3; k++) cyc(0, 7, 1'b1, 1'b0);
    @(negedge clk); e0 = 1'b0;
    reset = 1'b1;
    push_step(0, 0, 1'b0, 1'b0);
    cyc(0, 0, 1'b0, 1'b0);

    seq0(0, 6);                      // lock after sample 4
    seq0(6, 4);                      // last = 9
    cyc(0, 10, 1'b1, 1'b0); cyc(0, 11, 1'b1, 1'b0);
    cyc(0, 20, 1'b1, 1'b0); cyc(0, 21, 1'b1, 1'b0);
    seq0(0, 10);                     // restart, relock, last = 9
    cyc(0, 10, 1'b1, 1'b0); cyc(0, 40, 1'b1, 1'b0); cyc(0, 90, 1'b1, 1'b0);
    seq0(250, 9);                    // lock at 254, then 255,0,1,2 across the wrap
    seq0(3, 28);                     // up to 30
    cyc(0, 0, 1'b1, 1'b0);           // restart from 30
    cyc(0, 0, 1'b0, 1'b1);           // err_clr alone
    seq0(1, 6);
    for (int k = 0; k < 8; k++) cyc(0, $urandom_range(0, 255), 1'b0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) v = (m[0].last + 1) % 256;
      else if (r < 78) v = 0;
      else v = $urandom_range(0, 255);
      cyc(0, v, ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 5));
    end

    for (int k = 0; k < 6; k++) cyc(0, (m[0].last + 1) % 256, 1'b1, 1'b0);
    async_reset();
    cyc(0, 0, 1'b0, 1'b0);
    @(negedge clk); reset = 1'b1;
    push_step(0, 0, 1'b0, 1'b0);
    seq0(50, 6);

    // Saturation on instance 1: lock, then a long run of mismatches that never hit 0.
    for (int k = 1; k <= 5; k++) cyc(1, k, 1'b1, 1'b0);
    for (int k = 0; k < 65540; k++) cyc(1, (m[1].last + 2) % 256, 1'b1, 1'b0);
    cyc(1, (m[1].last + 2) % 256, 1'b1, 1'b1);
    cyc(1, 0, 1'b0, 1'b1);
    cyc(1, 0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("sat_final_locked", int'(lk1), 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
